pad_conditioner: RTL and testbench

- Sits directly upstream of the multitap and I/O port logic.
- Takes the four raw host joystick words and conditions them into the per-player, active-high button vectors that are then sliced onto the P1_..P4_ inputs.
- Provides:
  - an input capture register,
  - per-axis SOCD (opposing-direction) resolution,
  - frame-synchronous turbo (autofire) for A/B/C.
- All state advances only on CE, so output timing matches the port logic that samples it.

---
 rtl/pad_conditioner.sv | 197 +++++++++++++++++++
 tb/tb_pad_conditioner.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pad_conditioner.sv
// pad_conditioner
//   Conditions four raw host joystick words into active-high per-player button
//   vectors for the multitap / I/O port logic. Two CE-qualified stages:
//   stage 1 captures JOY_0..3 (and VBL), stage 2 registers the outputs after
//   SOCD resolution and turbo.
//
//   Optional feature macro: PAD_TURBO_EN (frame counter + autofire on A/B/C).
//   With it undefined, TURBO_PHASE is 0, JOY[14:12], VBL and TURBO_RATE are ignored.
//
// Ports:
//   CLK, RESET (async active-high), CE (clock enable)
//   VBL          vertical blank level; rising edge = frame tick
//   JOY_0..JOY_3 raw host words: [3:0]=U D L R, [6:4]=C B A, [11:7]=Z Y X MODE START,
//                [14:12]=turboC/B/A
//   SOCD_MODE    0 pass, 1/3 neutral, 2 last-wins
//   TURBO_RATE   autofire phase length = 2^TURBO_RATE frames
//   P1..P4       conditioned vectors, bits as JOY[11:0], 1 = pressed
//   TURBO_PHASE  current autofire phase
module pad_conditioner #(
  parameter int TURBO_CNT_W = 3
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CE,
  input  logic        VBL,
  input  logic [14:0] JOY_0,
  input  logic [14:0] JOY_1,
  input  logic [14:0] JOY_2,
  input  logic [14:0] JOY_3,
  input  logic [1:0]  SOCD_MODE,
  input  logic [1:0]  TURBO_RATE,
  output logic [11:0] P1,
  output logic [11:0] P2,
  output logic [11:0] P3,
  output logic [11:0] P4,
  output logic        TURBO_PHASE
);

`ifdef PAD_TURBO_EN
  localparam int JOY_CAP_W = 15;
`else
  localparam int JOY_CAP_W = 12;
`endif

  // Last-wins latch per axis: FIRST = R (L/R axis) or D (U/D axis),
  // SECOND = L or U.
  typedef enum logic [1:0] {
    LATCH_NONE   = 2'd0,
    LATCH_FIRST  = 2'd1,
    LATCH_SECOND = 2'd2
  } latch_e;

  logic [3:0][JOY_CAP_W-1:0] joy_s1_q, joy_s1_d;
  logic [3:0][3:0]           dir_prev_q, dir_prev_d;
  latch_e                    latch_q [4][2];
  latch_e                    latch_d [4][2];
  logic [3:0][11:0]          p_q, p_d;
  logic                      turbo_phase;

  function automatic latch_e latch_next(input logic a, input logic b,
                                        input logic pa, input logic pb,
                                        input latch_e cur);
    logic ra;
    logic rb;
    ra = a & ~pa;
    rb = b & ~pb;
    latch_next = cur;
    if (!a && !b)      latch_next = LATCH_NONE;
    else if (ra && rb) latch_next = LATCH_NONE;
    else if (ra)       latch_next = LATCH_FIRST;
    else if (rb)       latch_next = LATCH_SECOND;
    // Only one held (covers release of the latched side): it takes the latch.
    else if (a && !b)  latch_next = LATCH_FIRST;
    else if (b && !a)  latch_next = LATCH_SECOND;
  endfunction

  // Returns {second, first}.
  function automatic logic [1:0] socd_out(input logic a, input logic b,
                                          input latch_e nxt,
                                          input logic [1:0] mode);
    socd_out = {b, a};
    if (a && b) begin
      case (mode)
        2'd0: socd_out = 2'b11;
        2'd2: begin
          case (nxt)
            LATCH_FIRST:  socd_out = 2'b01;
            LATCH_SECOND: socd_out = 2'b10;
            default:      socd_out = 2'b00;
          endcase
        end
        default: socd_out = 2'b00;
      endcase
    end
  endfunction

  always_comb begin
    joy_s1_d   = joy_s1_q;
    dir_prev_d = dir_prev_q;
    latch_d    = latch_q;
    p_d        = p_q;
    if (CE) begin
      joy_s1_d = {JOY_3[JOY_CAP_W-1:0], JOY_2[JOY_CAP_W-1:0],
                  JOY_1[JOY_CAP_W-1:0], JOY_0[JOY_CAP_W-1:0]};
      for (int unsigned p = 0; p < 4; p++) begin
        dir_prev_d[p] = joy_s1_q[p][3:0];
        // Latches track in every mode so a mode switch mid-hold needs no reset.
        latch_d[p][0] = latch_next(joy_s1_q[p][0], joy_s1_q[p][1],
                                   dir_prev_q[p][0], dir_prev_q[p][1], latch_q[p][0]);
        latch_d[p][1] = latch_next(joy_s1_q[p][2], joy_s1_q[p][3],
                                   dir_prev_q[p][2], dir_prev_q[p][3], latch_q[p][1]);
        p_d[p][1:0]  = socd_out(joy_s1_q[p][0], joy_s1_q[p][1], latch_d[p][0], SOCD_MODE);
        p_d[p][3:2]  = socd_out(joy_s1_q[p][2], joy_s1_q[p][3], latch_d[p][1], SOCD_MODE);
`ifdef PAD_TURBO_EN
        p_d[p][6:4]  = joy_s1_q[p][6:4] | (joy_s1_q[p][14:12] & {3{turbo_phase}});
`else
        p_d[p][6:4]  = joy_s1_q[p][6:4];
`endif
        p_d[p][11:7] = joy_s1_q[p][11:7];
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      joy_s1_q   <= '0;
      dir_prev_q <= '0;
      p_q        <= '0;
      for (int unsigned p = 0; p < 4; p++) begin
        latch_q[p][0] <= LATCH_NONE;
        latch_q[p][1] <= LATCH_NONE;
      end
    end else begin
      joy_s1_q   <= joy_s1_d;
      dir_prev_q <= dir_prev_d;
      p_q        <= p_d;
      latch_q    <= latch_d;
    end
  end

`ifdef PAD_TURBO_EN
  logic                   vbl_s1_q, vbl_s1_d;
  logic                   vbl_prev_q, vbl_prev_d;
  logic [TURBO_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   phase_q, phase_d;
  logic [31:0]            turbo_lim;

  always_comb begin
    vbl_s1_d    = vbl_s1_q;
    vbl_prev_d  = vbl_prev_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    turbo_lim   = (32'd1 << TURBO_RATE) - 32'd1;
    if (CE) begin
      vbl_s1_d   = VBL;
      vbl_prev_d = vbl_s1_q;
      if (vbl_s1_q && !vbl_prev_q) begin
        // >= so a lowered rate wraps on the next edge instead of running past.
        if (32'(frame_cnt_q) >= turbo_lim) begin
          frame_cnt_d = '0;
          phase_d     = ~phase_q;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      vbl_s1_q    <= 1'b0;
      vbl_prev_q  <= 1'b0;
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      vbl_s1_q    <= vbl_s1_d;
      vbl_prev_q  <= vbl_prev_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign turbo_phase = phase_q;
`else
  logic unused_turbo_inputs;
  assign unused_turbo_inputs = ^{VBL, TURBO_RATE, JOY_0[14:12], JOY_1[14:12],
                                 JOY_2[14:12], JOY_3[14:12]};
  assign turbo_phase = 1'b0;
`endif

  assign P1          = p_q[0];
  assign P2          = p_q[1];
  assign P3          = p_q[2];
  assign P4          = p_q[3];
  assign TURBO_PHASE = turbo_phase;

endmodule

// File: tb/tb_pad_conditioner.sv
module tb_pad_conditioner;
  logic        CLK = 1'b0;
  logic        RESET;
  logic        CE;
  logic        VBL;
  logic [14:0] JOY_0, JOY_1, JOY_2, JOY_3;
  logic [1:0]  SOCD_MODE;
  logic [1:0]  TURBO_RATE;
  logic [11:0] P1, P2, P3, P4;
  logic        TURBO_PHASE;

  int n_assert = 0;
  int n_fail   = 0;

  pad_conditioner #(.TURBO_CNT_W(3)) dut (
    .CLK(CLK), .RESET(RESET), .CE(CE), .VBL(VBL),
    .JOY_0(JOY_0), .JOY_1(JOY_1), .JOY_2(JOY_2), .JOY_3(JOY_3),
    .SOCD_MODE(SOCD_MODE), .TURBO_RATE(TURBO_RATE),
    .P1(P1), .P2(P2), .P3(P3), .P4(P4), .TURBO_PHASE(TURBO_PHASE)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input logic ce);
    CE = ce;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
    end
  endtask

  // One VBL rising edge, then one more CE cycle so Pn reflects the new phase.
  task automatic vbl_pulse();
    VBL = 1'b1; tick(1'b1);
    VBL = 1'b0; tick(1'b1);
    tick(1'b1);
  endtask

  initial begin
    RESET = 1'b1; CE = 1'b0; VBL = 1'b0;
    JOY_0 = '0; JOY_1 = '0; JOY_2 = '0; JOY_3 = '0;
    SOCD_MODE = 2'd0; TURBO_RATE = 2'd0;
    tick(1'b0); tick(1'b0);
    RESET = 1'b0;

    // Reset behaviour
    JOY_0 = 15'h0FFF;
    tick(1'b1); tick(1'b1);
    chk("pre_reset_p1", P1, 12'hFFF);
    RESET = 1'b1;
    #1;
    chk("async_reset_p1", P1, 12'h000);
    chk("async_reset_p2", P2, 12'h000);
    chk("async_reset_p3", P3, 12'h000);
    chk("async_reset_p4", P4, 12'h000);
    chk("async_reset_phase", {11'd0, TURBO_PHASE}, 12'h000);
    #2;
    RESET = 1'b0;
    tick(1'b1);
    chk("post_reset_1ce_p1", P1, 12'h000);
    tick(1'b1);
    chk("post_reset_2ce_p1", P1, 12'hFFF);

    // Latency and CE hold
    JOY_0 = '0; JOY_1 = 15'h0010;
    tick(1'b1);
    chk("lat_ce1_p2", P2, 12'h000);
    tick(1'b0);
    chk("lat_celow_p2", P2, 12'h000);
    tick(1'b1);
    chk("lat_ce2_p2", P2, 12'h010);
    tick(1'b0);
    chk("lat_hold_p2", P2, 12'h010);
    JOY_1 = '0;

    // SOCD neutral and pass modes
    SOCD_MODE = 2'd1; JOY_0 = 15'h0003;
    tick(1'b1); tick(1'b1);
    chk("socd_m1_p1", P1, 12'h000);
    SOCD_MODE = 2'd0;
    tick(1'b1);
    chk("socd_m0_p1", P1, 12'h003);
    SOCD_MODE = 2'd3;
    tick(1'b1);
    chk("socd_m3_p1", P1, 12'h000);

    // SOCD last-wins on L/R
    SOCD_MODE = 2'd2; JOY_0 = '0;
    tick(1'b1); tick(1'b1);
    JOY_0 = 15'h0002;
    tick(1'b1); tick(1'b1);
    chk("lw_left_only", P1, 12'h002);
    JOY_0 = 15'h0003;
    tick(1'b1); tick(1'b1);
    chk("lw_add_right", P1, 12'h001);
    SOCD_MODE = 2'd1;
    tick(1'b1);
    chk("lw_switch_neutral", P1, 12'h000);
    SOCD_MODE = 2'd2;
    tick(1'b1);
    chk("lw_switch_back", P1, 12'h001);
    JOY_0 = 15'h0002;
    tick(1'b1); tick(1'b1);
    chk("lw_release_right", P1, 12'h002);

    // SOCD same-cycle rise on U/D
    JOY_0 = '0;
    tick(1'b1); tick(1'b1);
    JOY_0 = 15'h000C;
    tick(1'b1); tick(1'b1);
    chk("lw_same_cycle", P1, 12'h000);
    JOY_0 = 15'h0008;
    tick(1'b1); tick(1'b1);
    chk("lw_release_down", P1, 12'h008);
    JOY_0 = '0; SOCD_MODE = 2'd0;
    tick(1'b1); tick(1'b1);

`ifdef PAD_TURBO_EN
    // Turbo A on player 3, rate 1 (phase toggles every 2 edges)
    TURBO_RATE = 2'd1; JOY_2 = 15'h1000;
    tick(1'b1); tick(1'b1);
    chk("turbo_start", P3, 12'h000);
    vbl_pulse(); chk("turbo_e1", P3, 12'h000);
    vbl_pulse(); chk("turbo_e2", P3, 12'h010);
    chk("turbo_e2_phase", {11'd0, TURBO_PHASE}, 12'h001);
    vbl_pulse(); chk("turbo_e3", P3, 12'h010);
    vbl_pulse(); chk("turbo_e4", P3, 12'h000);
    JOY_2 = 15'h1010;
    vbl_pulse(); chk("turbo_press_e5", P3, 12'h010);
    vbl_pulse(); chk("turbo_press_e6", P3, 12'h010);
    chk("turbo_p4_idle", P4, 12'h000);
    // After edge 6: counter 0, phase 1. Rate 3 then drop to 0 mid-count.
    JOY_2 = 15'h1000; TURBO_RATE = 2'd3;
    vbl_pulse(); chk("rate3_e7", P3, 12'h010);
    vbl_pulse(); chk("rate3_e8", P3, 12'h010);
    TURBO_RATE = 2'd0;
    vbl_pulse(); chk("rate0_wrap_e9", P3, 12'h000);
    chk("rate0_wrap_phase", {11'd0, TURBO_PHASE}, 12'h000);
    vbl_pulse(); chk("rate0_e10", P3, 12'h010);
`else
    // Turbo compiled out: turbo bits ignored, phase stays 0
    JOY_3 = 15'h7000;
    for (int i = 0; i < 20; i++) begin
      vbl_pulse();
      chk("noturbo_p4", P4, 12'h000);
      chk("noturbo_phase", {11'd0, TURBO_PHASE}, 12'h000);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
